// File: rtl/max_frame_reducer_pkg.sv
// Shared types and default sizing for the max frame reducer.
package max_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_FRAME_LEN = 8;
  localparam int DEF_IDX_W     = $clog2(DEF_FRAME_LEN);

  // IDLE: no frame open; ACCUM: at least one beat of the current frame seen.
  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ACCUM = 1'b1
  } state_t;

  // One reduced frame at the default sizing.
  typedef struct packed {
    logic [DEF_WIDTH-1:0] max;
    logic [DEF_IDX_W-1:0] idx;
    logic [DEF_IDX_W:0]   count;
  } result_t;

endpackage

// File: rtl/max_frame_reducer_cmp.sv
// Unsigned a > b comparator; same function as the upstream compare partition.
module max_cmp_cell #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             gt
);

  assign gt = (a > b);

endmodule

// File: rtl/max_frame_reducer.sv
// Reduces each frame of a valid/ready sample stream to {max, first index, count}.
module max_frame_reducer
  import max_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int FRAME_LEN = DEF_FRAME_LEN,
  parameter int IDX_W     = $clog2(FRAME_LEN)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_max,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_count
);

  // Beat count at which a frame is forced closed.
  localparam logic [IDX_W:0] LAST_CNT = (IDX_W+1)'(FRAME_LEN);

  state_t           state;
  logic [IDX_W:0]   cnt;
  logic [WIDTH-1:0] cur_max;
  logic [IDX_W-1:0] cur_idx;

  logic             accept;
  logic             gt;
  logic             close;
  logic [WIDTH-1:0] nxt_max;
  logic [IDX_W-1:0] nxt_idx;
  logic [IDX_W:0]   nxt_cnt;

  // No skid buffer: a pending result blocks input until it is taken.
  assign in_ready = ~out_valid | out_ready;
  assign accept   = in_valid & in_ready;

  max_cmp_cell #(
    .WIDTH(WIDTH)
  ) u_cmp (
    .a (in_data),
    .b (cur_max),
    .gt(gt)
  );

  // Running result including the beat currently offered; strict > keeps the earliest tie.
  always_comb begin
    nxt_max = in_data;
    nxt_idx = '0;
    nxt_cnt = (IDX_W+1)'(1);
    if (state == S_ACCUM) begin
      nxt_max = gt ? in_data : cur_max;
      nxt_idx = gt ? cnt[IDX_W-1:0] : cur_idx;
      nxt_cnt = cnt + 1'b1;
    end
  end

  assign close = accept & (in_last | (nxt_cnt == LAST_CNT));

  // Frame FSM, accumulator and registered result port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= '0;
      cur_max   <= '0;
      cur_idx   <= '0;
      out_valid <= 1'b0;
      out_max   <= '0;
      out_idx   <= '0;
      out_count <= '0;
    end else begin
      if (close) begin
        state     <= S_IDLE;
        cnt       <= '0;
        cur_max   <= nxt_max;
        cur_idx   <= nxt_idx;
        out_valid <= 1'b1;
        out_max   <= nxt_max;
        out_idx   <= nxt_idx;
        out_count <= nxt_cnt;
      end else begin
        if (accept) begin
          state   <= S_ACCUM;
          cnt     <= nxt_cnt;
          cur_max <= nxt_max;
          cur_idx <= nxt_idx;
        end
        if (out_ready) begin
          out_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_max_frame_reducer.sv
// Directed bench for max_frame_reducer with a per-cycle frame-level reference model.
module tb_max_frame_reducer;

  localparam int WIDTH     = 4;
  localparam int FRAME_LEN = 8;
  localparam int IDX_W     = 3;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [WIDTH-1:0] in_data = '0;
  logic             in_last = 1'b0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] out_max;
  logic [IDX_W-1:0] out_idx;
  logic [IDX_W:0]   out_count;

  int compared = 0;
  int mismatched = 0;

  max_frame_reducer #(
    .WIDTH(WIDTH),
    .FRAME_LEN(FRAME_LEN),
    .IDX_W(IDX_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_last(in_last),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_max(out_max),
    .out_idx(out_idx),
    .out_count(out_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: collects the beats of the open frame and reduces them when it closes.
  int   frame_q[$];
  logic exp_valid = 1'b0;
  int   exp_max = 0, exp_idx = 0, exp_cnt = 0;

  initial begin
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        frame_q.delete();
        exp_valid = 1'b0;
        exp_max = 0;
        exp_idx = 0;
        exp_cnt = 0;
      end else begin
        automatic bit acc = in_valid && (!exp_valid || out_ready);
        automatic bit closed = 1'b0;
        if (acc) begin
          frame_q.push_back(int'(in_data));
          if (in_last || frame_q.size() == FRAME_LEN) begin
            exp_max = frame_q[0];
            exp_idx = 0;
            for (int i = 1; i < frame_q.size(); i++)
              if (frame_q[i] > exp_max) begin
                exp_max = frame_q[i];
                exp_idx = i;
              end
            exp_cnt = frame_q.size();
            frame_q.delete();
            closed = 1'b1;
          end
        end
        if (closed) exp_valid = 1'b1;
        else if (out_ready) exp_valid = 1'b0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      chk("in_ready", int'(in_ready), int'(!exp_valid || out_ready));
      chk("out_valid", int'(out_valid), int'(exp_valid));
      chk("out_max", int'(out_max), exp_max);
      chk("out_idx", int'(out_idx), exp_idx);
      chk("out_count", int'(out_count), exp_cnt);
    end
  end

  // Records every result the downstream takes, for literal checks.
  logic [10:0] got_q[$];
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && out_valid && out_ready) got_q.push_back({out_max, out_idx, out_count});
    end
  end

  task automatic expect_res(input string name, input int mx, input int ix, input int ct);
    logic [10:0] r;
    if (got_q.size() == 0) begin
      compared++;
      mismatched++;
      $display("FAIL %s: no result taken, expected %0d/%0d/%0d", name, mx, ix, ct);
    end else begin
      r = got_q.pop_front();
      chk({name, ".max"}, int'(r[10:7]), mx);
      chk({name, ".idx"}, int'(r[6:4]), ix);
      chk({name, ".count"}, int'(r[3:0]), ct);
    end
  endtask

  // Offers one beat, starting and ending 2 time units after a rising edge.
  task automatic beat(input int d, input bit l);
    bit ok;
    int n;
    ok = 1'b0;
    n = 0;
    in_valid = 1'b1;
    in_data = WIDTH'(d);
    in_last = l;
    while (!ok && n < 20) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #2;
      n++;
    end
    if (!ok) begin
      compared++;
      mismatched++;
      $display("FAIL beat_accept: got not accepted expected accepted within 20 cycles");
    end
    in_valid = 1'b0;
    in_last = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic frame(input int v[]);
    foreach (v[i]) beat(v[i], 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    // Reset state
    @(negedge clk);
    chk("rst.out_valid", int'(out_valid), 0);
    chk("rst.out_max", int'(out_max), 0);
    chk("rst.out_count", int'(out_count), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(2);

    // Full frame, no backpressure
    frame('{3, 9, 2, 9, 1, 0, 7, 5});
    idle(2);
    expect_res("full", 9, 1, 8);

    // Early close, then a fresh frame restarts at index 0
    beat(4, 1'b0);
    beat(6, 1'b1);
    beat(5, 1'b0);
    beat(3, 1'b1);
    idle(2);
    expect_res("early", 6, 1, 2);
    expect_res("restart", 5, 0, 2);

    // Back-to-back single-beat frames
    beat(15, 1'b1);
    beat(0, 1'b1);
    beat(8, 1'b1);
    idle(2);
    expect_res("b2b0", 15, 0, 1);
    expect_res("b2b1", 0, 0, 1);
    expect_res("b2b2", 8, 0, 1);

    // All-equal and all-zero frames
    frame('{5, 5, 5, 5, 5, 5, 5, 5});
    frame('{0, 0, 0, 0, 0, 0, 0, 0});
    idle(2);
    expect_res("equal", 5, 0, 8);
    expect_res("zero", 0, 0, 8);

    // Backpressure: result held for 5 cycles, then released with a beat in the same cycle
    out_ready = 1'b0;
    beat(7, 1'b0);
    beat(3, 1'b1);
    repeat (5) begin
      @(negedge clk);
      chk("bp.in_ready", int'(in_ready), 0);
      chk("bp.out_valid", int'(out_valid), 1);
      chk("bp.out_max", int'(out_max), 7);
      chk("bp.out_count", int'(out_count), 2);
      @(posedge clk);
      #2;
    end
    out_ready = 1'b1;
    beat(2, 1'b1);
    idle(2);
    expect_res("bp.held", 7, 0, 2);
    expect_res("bp.next", 2, 0, 1);

    // Reset mid-frame discards the partial frame
    frame('{12, 13, 14});
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst.out_valid", int'(out_valid), 0);
    chk("midrst.out_max", int'(out_max), 0);
    chk("midrst.out_idx", int'(out_idx), 0);
    chk("midrst.out_count", int'(out_count), 0);
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    idle(1);
    beat(1, 1'b0);
    beat(2, 1'b1);
    idle(2);
    expect_res("midrst", 2, 1, 2);

    chk("leftover_results", got_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
